// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state type and helpers for segment_readback
// Purpose: legal seven-segment patterns (bit6=a .. bit0=g, 1 = lit), the blank
//          pattern, illegal-digit markers, the readback FSM state type and the
//          BCD-to-binary helper.
// Ports:   none (package).
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_ILLEGAL   = 4'hF;
    localparam logic [6:0] VALUE_ILLEGAL = 7'd127;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // tens*10 + ones as shift-and-add; both digits are 0..9 so the sum fits 7 bits
    function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
    endfunction

endpackage

// File: rtl/segment_readback_if.sv
// rtl/segment_readback_if.sv - display-lines bus between a segment driver and segment_readback
// Purpose: groups the enable, the two segment buses and the decoded results.
// Signals: input_ENA, input_SEG1[6:0], input_SEG0[6:0] (driver -> reader);
//          output_Y1[3:0], output_Y0[3:0], output_VALUE[6:0], output_VALID,
//          output_ERR (reader -> driver).
// Modports: master = segment driver / observer, slave = segment_readback.
interface segment_readback_if;
    logic       input_ENA;
    logic [6:0] input_SEG1;
    logic [6:0] input_SEG0;
    logic [3:0] output_Y1;
    logic [3:0] output_Y0;
    logic [6:0] output_VALUE;
    logic       output_VALID;
    logic       output_ERR;

    modport master (
        output input_ENA, input_SEG1, input_SEG0,
        input  output_Y1, output_Y0, output_VALUE, output_VALID, output_ERR
    );

    modport slave (
        input  input_ENA, input_SEG1, input_SEG0,
        output output_Y1, output_Y0, output_VALUE, output_VALID, output_ERR
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational seven-segment pattern to BCD digit decoder
// Purpose: maps one 7-bit pattern to its digit, or BCD_ILLEGAL with illegal_o set.
// Parameter: BLANK_OK - when 1 the all-off pattern decodes as a legal 0.
// Ports: seg_i[6:0] pattern in; digit_o[3:0] digit out; illegal_o pattern not a digit.
module seg7_to_bcd
    import seg_pkg::*;
#(
    parameter bit BLANK_OK = 1'b0
) (
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       illegal_o
);

    always_comb begin
        digit_o   = BCD_ILLEGAL;
        illegal_o = 1'b1;
        case (seg_i)
            SEG_0:     begin digit_o = 4'd0; illegal_o = 1'b0; end
            SEG_1:     begin digit_o = 4'd1; illegal_o = 1'b0; end
            SEG_2:     begin digit_o = 4'd2; illegal_o = 1'b0; end
            SEG_3:     begin digit_o = 4'd3; illegal_o = 1'b0; end
            SEG_4:     begin digit_o = 4'd4; illegal_o = 1'b0; end
            SEG_5:     begin digit_o = 4'd5; illegal_o = 1'b0; end
            SEG_6:     begin digit_o = 4'd6; illegal_o = 1'b0; end
            SEG_7:     begin digit_o = 4'd7; illegal_o = 1'b0; end
            SEG_8:     begin digit_o = 4'd8; illegal_o = 1'b0; end
            SEG_9:     begin digit_o = 4'd9; illegal_o = 1'b0; end
            SEG_BLANK: begin
                if (BLANK_OK) begin
                    digit_o   = 4'd0;
                    illegal_o = 1'b0;
                end
            end
            default:   begin end
        endcase
    end

endmodule

// File: rtl/segment_readback.sv
// rtl/segment_readback.sv - two-digit seven-segment display readback with stability filter
// Purpose: synchronizes the tens/ones segment buses, waits for STABLE_CYCLES identical
//          samples, then decodes the word to Y1/Y0/VALUE/ERR and strobes VALID when the
//          accepted word is new.
// Ports:  input_CLK, input_RSTn (async, active low), bus (segment_readback_if.slave).
// Param:  STABLE_CYCLES (1..255).
// Macro:  SEG_LEADING_BLANK_EN - all-off tens pattern decodes as 0 (leading-zero blanking).
module segment_readback
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                input_CLK,
    input  logic                input_RSTn,
    segment_readback_if.slave   bus
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

`ifdef SEG_LEADING_BLANK_EN
    localparam bit TENS_BLANK_OK = 1'b1;
`else
    localparam bit TENS_BLANK_OK = 1'b0;
`endif

    logic [13:0] sync1_q, sync2_q;
    logic        ena_q;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic        acc_q, acc_d;
    logic [13:0] acc_word_q, acc_word_d;
    logic        valid_q, valid_d;
    logic [3:0]  y1_q, y0_q;
    logic [6:0]  value_q, value_d;
    logic        err_q, err_d;
    logic        same, accept;
    logic [3:0]  tens_digit, ones_digit;
    logic        tens_bad, ones_bad;

    seg7_to_bcd #(.BLANK_OK(TENS_BLANK_OK)) u_tens (
        .seg_i     (sync2_q[13:7]),
        .digit_o   (tens_digit),
        .illegal_o (tens_bad)
    );

    seg7_to_bcd #(.BLANK_OK(1'b0)) u_ones (
        .seg_i     (sync2_q[6:0]),
        .digit_o   (ones_digit),
        .illegal_o (ones_bad)
    );

    // sync1_q is the synchronized word of the next cycle, so comparing it with
    // sync2_q tells whether the synchronized word holds across the coming edge.
    // ENA is registered once so the filter and FSM see it on the same footing.
    always_comb begin
        same    = (sync1_q == sync2_q);
        cnt_inc = (cnt_q >= STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!ena_q) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
                SETTLE: begin
                    cnt_d = same ? cnt_inc : 8'd0;
                    if (same && cnt_inc == STABLE_MAX) begin
                        state_d = LOCKED;
                        accept  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        state_d = SETTLE;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // Leaving through IDLE forgets the accepted word so the next one strobes.
        acc_d      = (state_d == IDLE) ? 1'b0 : acc_q;
        acc_word_d = acc_word_q;
        valid_d    = accept && (!acc_q || sync2_q != acc_word_q);
        if (accept) begin
            acc_d      = 1'b1;
            acc_word_d = sync2_q;
        end

        err_d   = tens_bad | ones_bad;
        value_d = err_d ? VALUE_ILLEGAL : bcd_value(tens_digit, ones_digit);
    end

    always_ff @(posedge input_CLK or negedge input_RSTn) begin
        if (!input_RSTn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            ena_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            acc_q      <= 1'b0;
            acc_word_q <= '0;
            valid_q    <= 1'b0;
            y1_q       <= 4'd0;
            y0_q       <= 4'd0;
            value_q    <= 7'd0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= {bus.input_SEG1, bus.input_SEG0};
            sync2_q    <= sync1_q;
            ena_q      <= bus.input_ENA;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_word_q <= acc_word_d;
            valid_q    <= valid_d;
            if (accept) begin
                y1_q    <= tens_digit;
                y0_q    <= ones_digit;
                value_q <= value_d;
                err_q   <= err_d;
            end
        end
    end

    assign bus.output_Y1    = y1_q;
    assign bus.output_Y0    = y0_q;
    assign bus.output_VALUE = value_q;
    assign bus.output_VALID = valid_q;
    assign bus.output_ERR   = err_q;

endmodule
